// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the SRAM read/write controller.
//   state_e       controller FSM states (sweep-clearing vs. serving requests)
//   RdLatMin/Max  legal read-latency range of the controller
//   be_mask_bit   maps a bit position of a word to its byte-enable
package sram_pkg;

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StIdle  = 1'b1
    } state_e;

    localparam int unsigned RdLatMin = 1;
    localparam int unsigned RdLatMax = 2;

    // Widest byte-enable vector the mask helper accepts (512-bit words).
    localparam int unsigned MaxBytes = 64;

    // Write-mask bit for word bit bit_idx: the enable of the byte lane holding it.
    function automatic logic be_mask_bit(input logic [MaxBytes-1:0] be,
                                         input int unsigned        bit_idx);
        return be[6'(bit_idx / 8)];
    endfunction

endpackage

// File: rtl/sram_array.sv
// sram_array: synchronous single-port RAM, one operation per cycle.
//   pulse  clock (rising edge)
//   we     write enable; bytes selected by be are updated, others preserved
//   re     read enable; rdata loads mem[addr] on the edge and holds otherwise
//   addr   word index (caller guarantees addr < DEPTH when we/re are set)
//   wdata  write data
//   be     byte-lane write enables
//   rdata  registered read data
// The array has no reset; contents are defined only once written.
module sram_array
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    pulse,
    input  logic                    we,
    input  logic                    re,
    input  logic [IDX_WIDTH-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wmask;

    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            wmask[i] = be_mask_bit(MaxBytes'(be), i);
        end
    end

    always_ff @(posedge pulse) begin
        if (we) begin
            mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl: request/response front end for sram_array with a zeroing sweep.
//   pulse      clock (rising edge)
//   rst_n      asynchronous active-low reset; restarts the zeroing sweep
//   clr_start  one-cycle request to zero the whole array (ignored while clearing)
//   req_*      request channel (valid/ready handshake, we, addr, wdata, be)
//   rsp_valid  one-cycle read-data pulse, RD_LAT cycles after acceptance
//   rsp_rdata  read data; holds its last value while rsp_valid is low
//   rsp_err    one-cycle pulse for an accepted request with req_addr >= DEPTH
//   clr_busy   high while the zeroing sweep runs
module sram_rw_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                    pulse,
    input  logic                    rst_n,
    input  logic                    clr_start,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    clr_busy
);

    localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH does not wrap to zero.
    localparam logic [ADDR_WIDTH:0]  DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IdxWidth-1:0]  LastIdx  = IdxWidth'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic [IdxWidth-1:0]     sweep_q, sweep_d;

    logic                    addr_oor;
    logic                    accept;
    logic                    mem_we, mem_re;
    logic [IdxWidth-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    assign addr_oor = {1'b0, req_addr} >= DepthExt;
    assign accept   = req_valid && req_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge pulse or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClear;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            StClear: begin
                if (sweep_q == LastIdx) begin
                    state_d = StIdle;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + IdxWidth'(1);
                end
            end
            StIdle: begin
                // A request accepted in this same cycle still completes on this edge.
                if (clr_start) begin
                    state_d = StClear;
                    sweep_d = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    // ---------------- FSM: outputs / memory port ----------------
    always_comb begin
        req_ready = 1'b0;
        clr_busy  = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = req_addr[IdxWidth-1:0];
        mem_wdata = req_wdata;
        mem_be    = req_be;
        unique case (state_q)
            StClear: begin
                clr_busy  = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sweep_q;
                mem_wdata = '0;
                mem_be    = '1;
            end
            StIdle: begin
                req_ready = 1'b1;
                mem_we    = req_valid && req_we && !addr_oor;
                mem_re    = req_valid && !req_we && !addr_oor;
            end
            default: ;
        endcase
    end

    sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IdxWidth)
    ) u_array (
        .pulse (pulse),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .be    (mem_be),
        .rdata (mem_rdata)
    );

    // ---------------- response tracking ----------------
    // Stage 1 lines up with the RAM's registered read output.
    logic                  s1_valid_q, s1_read_q, s1_err_q;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge pulse or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_read_q  <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s1_read_q  <= !req_we;
            s1_err_q   <= addr_oor;
        end
    end

    // Out-of-range reads never touch the RAM, so their data is forced to zero.
    assign s1_data = s1_err_q ? '0 : mem_rdata;

    logic                  out_valid, out_read, out_err;
    logic [DATA_WIDTH-1:0] out_data;

    if (RD_LAT >= RdLatMax) begin : gen_lat2
        logic                  s2_valid_q, s2_read_q, s2_err_q;
        logic [DATA_WIDTH-1:0] s2_data_q;

        always_ff @(posedge pulse or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_read_q  <= 1'b0;
                s2_err_q   <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_read_q  <= s1_read_q;
                s2_err_q   <= s1_err_q;
                if (s1_valid_q && s1_read_q) begin
                    s2_data_q <= s1_data;
                end
            end
        end

        assign out_valid = s2_valid_q;
        assign out_read  = s2_read_q;
        assign out_err   = s2_err_q;
        assign out_data  = s2_data_q;
    end else begin : gen_lat1
        assign out_valid = s1_valid_q;
        assign out_read  = s1_read_q;
        assign out_err   = s1_err_q;
        assign out_data  = s1_data;
    end

    // hold_q keeps the last delivered word so rsp_rdata is stable between pulses.
    logic [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge pulse or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (rsp_valid) begin
            hold_q <= out_data;
        end
    end

    assign rsp_valid = out_valid && out_read;
    assign rsp_err   = out_valid && out_err;
    assign rsp_rdata = rsp_valid ? out_data : hold_q;

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Bench for sram_rw_ctrl: two instances (DEPTH=1000/RD_LAT=2/16-bit and
// DEPTH=16/RD_LAT=1/32-bit) share one stimulus stream. A behavioural model
// (word arrays, sweep countdown, ring of scheduled responses) predicts every
// output of both instances each cycle; directed sequences add literal checks.
module tb_sram_rw_ctrl;

    logic        pulse = 1'b0;
    logic        rst_n, clr_start, req_valid, req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        r0_ready, r0_valid, r0_err, r0_busy;
    logic [15:0] r0_rdata;
    logic        r1_ready, r1_valid, r1_err, r1_busy;
    logic [31:0] r1_rdata;

    always #5 pulse = ~pulse;

    sram_rw_ctrl #(
        .DATA_WIDTH (16), .DEPTH (1000), .ADDR_WIDTH (16), .RD_LAT (2)
    ) u_dut0 (
        .pulse (pulse), .rst_n (rst_n), .clr_start (clr_start),
        .req_valid (req_valid), .req_ready (r0_ready), .req_we (req_we),
        .req_addr (req_addr), .req_wdata (req_wdata[15:0]), .req_be (req_be[1:0]),
        .rsp_valid (r0_valid), .rsp_rdata (r0_rdata), .rsp_err (r0_err),
        .clr_busy (r0_busy)
    );

    sram_rw_ctrl #(
        .DATA_WIDTH (32), .DEPTH (16), .ADDR_WIDTH (5), .RD_LAT (1)
    ) u_dut1 (
        .pulse (pulse), .rst_n (rst_n), .clr_start (clr_start),
        .req_valid (req_valid), .req_ready (r1_ready), .req_we (req_we),
        .req_addr (req_addr[4:0]), .req_wdata (req_wdata), .req_be (req_be),
        .rsp_valid (r1_valid), .rsp_rdata (r1_rdata), .rsp_err (r1_err),
        .clr_busy (r1_busy)
    );

    // ---------------- behavioural model ----------------
    int unsigned depth_m [2] = '{1000, 16};
    int unsigned lat_m   [2] = '{2, 1};
    int unsigned nb_m    [2] = '{2, 4};
    logic [15:0] amask_m [2] = '{16'hFFFF, 16'h001F};
    logic [31:0] dmask_m [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};

    logic [31:0] mem_m [2][1024];
    int unsigned clr_left [2];
    logic        sv [2][4];
    logic        se [2][4];
    logic [31:0] sd [2][4];
    logic [31:0] last_d [2];
    int unsigned cyc = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            clr_left[k] = depth_m[k];
            last_d[k]   = '0;
            for (int s = 0; s < 4; s++) begin
                sv[k][s] = 1'b0; se[k][s] = 1'b0; sd[k][s] = '0;
            end
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        int unsigned slot, ns, a;
        logic oor;
        slot = cyc % 4;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sv[k][slot]) last_d[k] = sd[k][slot];
                sv[k][slot] = 1'b0; se[k][slot] = 1'b0; sd[k][slot] = '0;
                if (clr_left[k] > 0) begin
                    mem_m[k][depth_m[k] - clr_left[k]] = '0;
                    clr_left[k]--;
                end else begin
                    if (req_valid) begin
                        a   = int'(req_addr & amask_m[k]);
                        oor = (a >= depth_m[k]);
                        ns  = (cyc + lat_m[k]) % 4;
                        if (req_we) begin
                            if (oor) se[k][ns] = 1'b1;
                            else begin
                                for (int b = 0; b < int'(nb_m[k]); b++)
                                    if (req_be[b]) mem_m[k][a][8*b +: 8] = req_wdata[8*b +: 8];
                            end
                        end else begin
                            sv[k][ns] = 1'b1;
                            se[k][ns] = oor;
                            sd[k][ns] = oor ? 32'h0 : mem_m[k][a];
                        end
                    end
                    if (clr_start) clr_left[k] = depth_m[k];
                end
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        int unsigned slot;
        logic [31:0] exp_d;
        slot = cyc % 4;
        for (int k = 0; k < 2; k++) begin
            exp_d = (sv[k][slot] ? sd[k][slot] : last_d[k]) & dmask_m[k];
            if (k == 0) begin
                check("d0_ready", {31'b0, r0_ready}, {31'b0, clr_left[0] == 0});
                check("d0_busy",  {31'b0, r0_busy},  {31'b0, clr_left[0] != 0});
                check("d0_valid", {31'b0, r0_valid}, {31'b0, sv[0][slot]});
                check("d0_err",   {31'b0, r0_err},   {31'b0, se[0][slot]});
                check("d0_rdata", {16'b0, r0_rdata}, exp_d);
            end else begin
                check("d1_ready", {31'b0, r1_ready}, {31'b0, clr_left[1] == 0});
                check("d1_busy",  {31'b0, r1_busy},  {31'b0, clr_left[1] != 0});
                check("d1_valid", {31'b0, r1_valid}, {31'b0, sv[1][slot]});
                check("d1_err",   {31'b0, r1_err},   {31'b0, se[1][slot]});
                check("d1_rdata", r1_rdata, exp_d);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        model_step();
        @(negedge pulse);
        compare_all();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        clr_start = 1'b0;
        cycle();
    endtask

    task automatic do_req(input logic we, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        clr_start = 1'b0;
        cycle();
        req_valid = 1'b0;
    endtask

    // Counts cycles until DUT0 leaves its sweep (bounded).
    task automatic count_busy(output int n);
        n = 0;
        while (r0_busy && n < 1100) begin
            idle();
            n++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
    endtask

    int n, nv, nz;

    initial begin
        rst_n = 1'b1; clr_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 1024; i++) mem_m[k][i] = '0;
        #2;
        apply_reset();
        check("reset_busy", {31'b0, r0_busy}, 32'd1);
        check("reset_ready", {31'b0, r0_ready}, 32'd0);
        @(negedge pulse);
        idle(); idle();
        rst_n = 1'b1;

        // Power-up sweep length, then a read of a freshly zeroed word.
        count_busy(n);
        check("sweep_len", n, 32'd1000);
        check("ready_after_sweep", {31'b0, r0_ready}, 32'd1);
        do_req(1'b0, 16'd5, '0, '0);
        idle();
        check("rd5_valid", {31'b0, r0_valid}, 32'd1);
        check("rd5_data", {16'b0, r0_rdata}, 32'h0);

        // Byte-lane merge.
        do_req(1'b1, 16'd3, 32'hBEEF, 4'b0011);
        do_req(1'b1, 16'd3, 32'h1200, 4'b0010);
        do_req(1'b0, 16'd3, '0, '0);
        idle();
        check("merge_valid", {31'b0, r0_valid}, 32'd1);
        check("merge_data", {16'b0, r0_rdata}, 32'h12EF);
        idle();
        check("hold_valid", {31'b0, r0_valid}, 32'd0);
        check("hold_data", {16'b0, r0_rdata}, 32'h12EF);

        // Write then immediate read of the same word.
        do_req(1'b1, 16'd11, 32'h0000_7A7A, 4'b0011);
        do_req(1'b0, 16'd11, '0, '0);
        idle();
        check("raw_data", {16'b0, r0_rdata}, 32'h7A7A);

        // Back-to-back reads 0..7.
        for (int i = 0; i < 8; i++) begin
            if (i != 3) do_req(1'b1, 16'(i), 32'(16'hA000 + 16'(i) * 16'h0111), 4'b0011);
        end
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) do_req(1'b0, 16'(i), '0, '0);
            else idle();
            if (r0_valid) begin
                if (nv == 3) check("b2b_data3", {16'b0, r0_rdata}, 32'h12EF);
                else check("b2b_data", {16'b0, r0_rdata}, 32'(16'hA000 + 16'(nv) * 16'h0111));
                nv++;
            end
        end
        check("b2b_count", nv, 32'd8);

        // Out-of-range write and read.
        do_req(1'b1, 16'd1000, 32'hDEAD, 4'b0011);
        idle();
        check("oorw_err", {31'b0, r0_err}, 32'd1);
        check("oorw_valid", {31'b0, r0_valid}, 32'd0);
        do_req(1'b0, 16'd1000, '0, '0);
        idle();
        check("oorr_err", {31'b0, r0_err}, 32'd1);
        check("oorr_valid", {31'b0, r0_valid}, 32'd1);
        check("oorr_data", {16'b0, r0_rdata}, 32'h0);
        do_req(1'b0, 16'd999, '0, '0);
        idle();
        check("oor_neighbour", {16'b0, r0_rdata}, 32'h0);

        // Clear sweep after nonzero data, then every word reads zero.
        req_valid = 1'b0; clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        n = 0;
        while (!r0_ready && n < 1100) begin
            idle();
            n++;
        end
        check("clr_len", n, 32'd1000);
        nv = 0; nz = 0;
        for (int i = 0; i < 1002; i++) begin
            if (i < 1000) do_req(1'b0, 16'(i), '0, '0);
            else idle();
            if (r0_valid) begin
                nv++;
                if (r0_rdata != 16'h0) nz++;
            end
        end
        check("clr_reads", nv, 32'd1000);
        check("clr_nonzero", nz, 32'd0);

        // Reset in the middle of a sweep (next word to clear is 500).
        do_req(1'b1, 16'd9, 32'h5A5A, 4'b0011);
        do_req(1'b0, 16'd9, '0, '0);
        idle(); idle();
        check("pre_rst_data", {16'b0, r0_rdata}, 32'h5A5A);
        req_valid = 1'b0; clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        for (int i = 0; i < 500; i++) idle();
        apply_reset();
        check("rst_ready", {31'b0, r0_ready}, 32'd0);
        check("rst_valid", {31'b0, r0_valid}, 32'd0);
        check("rst_err", {31'b0, r0_err}, 32'd0);
        check("rst_rdata", {16'b0, r0_rdata}, 32'h0);
        check("rst_busy", {31'b0, r0_busy}, 32'd1);
        @(negedge pulse);
        idle();
        rst_n = 1'b1;
        count_busy(n);
        check("resweep_len", n, 32'd1000);

        // Randomised traffic, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 5) req_addr = 16'($urandom_range(0, 31));
            else if (r < 9) req_addr = 16'($urandom_range(0, 1023));
            else req_addr = 16'($urandom_range(1000, 65535));
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = $urandom_range(0, 1) == 1;
            req_wdata = $urandom;
            req_be    = 4'($urandom);
            clr_start = ($urandom_range(0, 599) == 0);
            if (i == 2500) begin
                apply_reset();
                @(negedge pulse);
                rst_n = 1'b1;
            end
            cycle();
        end
        idle(); idle(); idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
